// File: rtl/updown_counter_n.sv
// Purpose : parametrised up/down counter, modulus MODULUS, wrap or saturate, sync load, cascadable tc.
// Latency : Q and tc registered, 1 cycle from sampled inputs; at_max/at_min combinational from Q.
// Backpr. : none; enable is the only throttle, and tc of one stage drives enable of the next.
//
// Ports:
//    clk        - rising-edge clock
//    rst_n      - asynchronous active-low reset (Q=0, tc=0)
//    enable     - count enable; Q holds when low
//    up_down    - direction: 1 = up, 0 = down
//    load       - synchronous load, overrides enable/up_down
//    load_value - value to load, clamped to MODULUS-1
//    Q          - current count, always within 0..MODULUS-1
//    tc         - one-cycle terminal-count pulse (held while saturated and still counting)
//    at_max     - Q == MODULUS-1
//    at_min     - Q == 0
module updown_counter_n #(
   parameter int WIDTH    = 3,
   parameter int MODULUS  = 8,
   parameter int SATURATE = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enable,
   input  logic             up_down,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   output logic [WIDTH-1:0] Q,
   output logic             tc,
   output logic             at_max,
   output logic             at_min
);

   // Reject illegal configurations at elaboration time.
   generate
      if (WIDTH < 1 || WIDTH > 16) begin : g_bad_width
         $error("updown_counter_n: WIDTH must be in 1..16");
      end
      if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
         $error("updown_counter_n: MODULUS must be in 2..2**WIDTH");
      end
   endgenerate

   localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
   localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
   localparam bit               SAT     = (SATURATE != 0);

   logic [WIDTH-1:0] r_q;
   logic             r_tc;
   logic [WIDTH-1:0] w_q_nxt;
   logic             w_tc_nxt;

   always_comb begin
      w_q_nxt  = r_q;
      w_tc_nxt = 1'b0;
      if (load) begin
         // Out-of-range loads clamp to the top of the range rather than wrapping.
         w_q_nxt = (load_value > MAX_VAL) ? MAX_VAL : load_value;
      end else if (enable) begin
         if (up_down) begin
            if (r_q == MAX_VAL) begin
               w_tc_nxt = 1'b1;
               w_q_nxt  = SAT ? r_q : '0;
            end else begin
               w_q_nxt = r_q + ONE;
            end
         end else begin
            if (r_q == '0) begin
               w_tc_nxt = 1'b1;
               w_q_nxt  = SAT ? r_q : MAX_VAL;
            end else begin
               w_q_nxt = r_q - ONE;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_q  <= '0;
         r_tc <= 1'b0;
      end else begin
         r_q  <= w_q_nxt;
         r_tc <= w_tc_nxt;
      end
   end

   assign Q      = r_q;
   assign tc     = r_tc;
   // Decoded from the register only, so these never see input glitches.
   assign at_max = (r_q == MAX_VAL);
   assign at_min = (r_q == '0);

endmodule
